// File: rtl/vc_bus_pkg.sv
// Shared definitions for the vc32 pad-bus memory responder: strobe codes,
// tracking-FSM states and the default physical address width.
package vc_bus_pkg;

  localparam int unsigned PA_DEFAULT = 18;

  // Strobe codes are {latch_hi, latch_lo}
  localparam logic [1:0] STB_NONE = 2'b00;
  localparam logic [1:0] STB_LO   = 2'b01;
  localparam logic [1:0] STB_HI   = 2'b10;
  localparam logic [1:0] STB_MID  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StMid,
    StLo,
    StWr
  } bus_state_e;

endpackage

// File: rtl/vc_bus_mem_if.sv
// CPU pad-bus bundle: multiplexed address/data byte, strobes and the
// responder's read data, interrupt and protocol-error returns.
interface vc_bus_mem_if;

  logic [7:0] bus_in;
  logic       latch_lo;
  logic       latch_hi;
  logic       write;
  logic       ind;
  logic [7:0] rd_data;
  logic       irq;
  logic       proto_err;

  modport master (
    output bus_in, latch_lo, latch_hi, write, ind,
    input  rd_data, irq, proto_err
  );

  modport slave (
    input  bus_in, latch_lo, latch_hi, write, ind,
    output rd_data, irq, proto_err
  );

endinterface

// File: rtl/vc_bus_irq_timer.sv
// 8-bit one-shot down-counter; irq rises when the count runs out and is
// cleared by the next load.
module vc_bus_irq_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       irq
);

  logic [7:0] count_q, count_d;
  logic       irq_q, irq_d;

  always_comb begin
    count_d = count_q;
    irq_d   = irq_q;
    if (load) begin
      count_d = load_val;
      irq_d   = 1'b0;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
      if (count_q == 8'd1) irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/vc_bus_mem.sv
// Byte-wide external memory responder for the vc32 pad bus: three-phase
// address latch, async-read byte array, sequence checker. Optional timer
// irq when VC_BUS_MEM_IRQ_EN is defined.
module vc_bus_mem
  import vc_bus_pkg::*;
#(
  parameter int unsigned     PA         = PA_DEFAULT,
  parameter int unsigned     DEPTH_LOG2 = 12,
  parameter string           INIT_FILE  = "",
  parameter logic [PA-1:0]   IRQ_ADDR   = 18'h3ffff
) (
  input  logic         clk,
  input  logic         reset,
  vc_bus_mem_if.slave  bus
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [1:0]    code;
  logic [PA-1:1] addr_q;
  logic [PA-1:0] eff;
  logic          wr_en;
  logic [7:0]    mem [Depth];

  bus_state_e state_q, state_d;
  logic       wr_second_q, wr_second_d;
  logic       err_q, err_d;
  logic       viol;

  assign code = {bus.latch_hi, bus.latch_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      case (code)
        STB_HI:  addr_q[PA-1:16] <= bus.bus_in[PA-17:0];
        STB_MID: addr_q[15:8]    <= bus.bus_in;
        STB_LO:  addr_q[7:1]     <= bus.bus_in[7:1];
        default: ;
      endcase
    end
  end

  // Low-address bypass: the CPU samples read data during the lo-only phase
  always_comb begin
    eff = {addr_q, bus.ind};
    if (code == STB_LO) eff[7:1] = bus.bus_in[7:1];
  end

  assign wr_en = bus.write && (code == STB_NONE) && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) mem[eff[DEPTH_LOG2-1:0]] <= bus.bus_in;
  end

  assign bus.rd_data = mem[eff[DEPTH_LOG2-1:0]];

  // Sequence checker: flags violations, never gates the access itself
  always_comb begin
    state_d     = state_q;
    wr_second_d = wr_second_q;
    err_d       = err_q;
    viol        = 1'b0;
    if (bus.write && code != STB_NONE) begin
      viol = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (code == STB_HI) state_d = StHi;
          else if (code != STB_NONE || bus.write) viol = 1'b1;
        end
        StHi: begin
          if (code == STB_MID) state_d = StMid;
          else if (code != STB_HI) viol = 1'b1;
        end
        StMid: begin
          if (code == STB_LO) state_d = StLo;
          else if (code != STB_MID) viol = 1'b1;
        end
        StLo: begin
          if (code == STB_NONE) begin
            state_d     = bus.write ? StWr : StIdle;
            wr_second_d = 1'b0;
          end else if (code != STB_LO) begin
            viol = 1'b1;
          end
        end
        StWr: begin
          if (code != STB_NONE) viol = 1'b1;
          else if (!bus.write) state_d = StIdle;
          else if (wr_second_q) viol = 1'b1;
          else wr_second_d = 1'b1;
        end
        default: viol = 1'b1;
      endcase
    end
    if (viol) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_second_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_second_q <= wr_second_d;
      err_q       <= err_d;
    end
  end

  assign bus.proto_err = err_q;

`ifdef VC_BUS_MEM_IRQ_EN
  logic irq;

  vc_bus_irq_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (wr_en && (eff == IRQ_ADDR)),
    .load_val (bus.bus_in),
    .irq      (irq)
  );

  assign bus.irq = irq;
`else
  logic unused_irq_bits;
  assign unused_irq_bits = ^{IRQ_ADDR, eff[PA-1:DEPTH_LOG2]};
  assign bus.irq = 1'b0;
`endif

endmodule
